// File: rtl/pcie_stim_gen.sv
// pcie_stim_gen: burst data stimulus source with valid/ready handshake, gaps and pattern modes
// Ports: clock/reset (async, active-high); start/stop control; mode/seed/burst_len/gap_len/num_bursts
// config latched at start; ready backpressure in; valid/data_out stream out; busy/done/word_count status.
module pcie_stim_gen #(
  parameter int          DATA_W = 32,
  parameter int          LEN_W  = 8,
  parameter int          GAP_W  = 4,
  parameter logic [31:0] POLY   = 32'h04C11DB7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [GAP_W-1:0]  gap_len,
  input  logic [LEN_W-1:0]  num_bursts,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic [15:0]       word_count
);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  localparam logic [DATA_W-1:0] poly = DATA_W'(POLY);
  state_t            state;
  logic [1:0]        mode_q;
  logic [LEN_W-1:0]  burst_len_q, num_bursts_q, beat_cnt, burst_cnt;
  logic [GAP_W-1:0]  gap_len_q, gap_cnt;
  logic [DATA_W-1:0] pat, nxt;
  logic              stop_pend, xfer, last_word, last_burst, halt;
  function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] d, input logic [1:0] m);
    return m == 2'd0 ? d :
           m == 2'd1 ? d + DATA_W'(1) :
           m == 2'd2 ? {d[DATA_W-2:0], 1'b0} ^ (d[DATA_W-1] ? poly : '0) :
                       {d[DATA_W-2:0], d[DATA_W-1]};
  endfunction
  assign nxt        = adv(data_out, mode_q);
  assign xfer       = valid && ready;
  assign last_word  = beat_cnt == burst_len_q - LEN_W'(1);
  // num_bursts of zero means run until stop, so it never matches here
  assign last_burst = (num_bursts_q != '0) && (burst_cnt == num_bursts_q - LEN_W'(1));
  // stop may be released while the held word waits for ready; remember it
  assign halt       = stop || stop_pend;
  assign busy       = state != IDLE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      valid        <= 1'b0;
      data_out     <= '0;
      done         <= 1'b0;
      word_count   <= '0;
      mode_q       <= '0;
      burst_len_q  <= '0;
      num_bursts_q <= '0;
      gap_len_q    <= '0;
      beat_cnt     <= '0;
      burst_cnt    <= '0;
      gap_cnt      <= '0;
      pat          <= '0;
      stop_pend    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode_q       <= mode;
          burst_len_q  <= burst_len;
          num_bursts_q <= num_bursts;
          gap_len_q    <= gap_len;
          word_count   <= '0;
          beat_cnt     <= '0;
          burst_cnt    <= '0;
          stop_pend    <= 1'b0;
          if (burst_len == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= SEND;
            valid    <= 1'b1;
            // LFSR and rotate would lock up on an all-zero word
            data_out <= (mode[1] && seed == '0) ? DATA_W'(1) : seed;
          end
        end
        SEND: if (xfer) begin
          word_count <= word_count + 16'd1;
          if (last_word) begin
            beat_cnt  <= '0;
            burst_cnt <= burst_cnt + LEN_W'(1);
            if (last_burst || halt) begin
              state <= DONE;
              valid <= 1'b0;
              done  <= 1'b1;
            end else if (gap_len_q != '0) begin
              state   <= GAP;
              valid   <= 1'b0;
              gap_cnt <= gap_len_q - GAP_W'(1);
              pat     <= nxt;
            end else begin
              data_out <= nxt;
            end
          end else if (halt) begin
            state <= DONE;
            valid <= 1'b0;
            done  <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            data_out <= nxt;
          end
        end else if (stop) begin
          stop_pend <= 1'b1;
        end
        GAP: if (stop) begin
          state <= DONE;
          done  <= 1'b1;
        end else if (gap_cnt == '0) begin
          state    <= SEND;
          valid    <= 1'b1;
          data_out <= pat;
        end else begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
